// File: rtl/add_digit_serial_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state
// encoding and the counter-width helper.
package add_digit_serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Ceiling log2, never below 1 so a single-digit build still has a counter bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/add_digit_serial_add_digit.sv
// One DIGIT-wide ripple-carry slice built from full-adder cells; also exposes
// the carry into its MSB so the top can derive signed overflow.
module add_full (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module add_digit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);
  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_bit
    add_full u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co    = c[W];
  assign c_msb = c[W-1];
endmodule

// File: rtl/add_digit_serial.sv
// Multi-cycle two's-complement adder/subtractor: WIDTH-bit operands are
// processed DIGIT bits per clock through a single ripple slice.
module add_digit_serial
  import add_digit_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output state_e           state_dbg
);
  // Handshake: start is sampled only in S_IDLE; busy covers RUN and DONE;
  // done is a one-cycle pulse during which sum/cout/ovf are valid.
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = clog2_min1(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] dig_a, dig_b, dig_s;
  logic             dig_co, dig_cmsb;
  int               dig_base;

  assign dig_base = int'(cnt_q) * DIGIT;
  assign dig_a    = a_q[dig_base +: DIGIT];
  assign dig_b    = b_q[dig_base +: DIGIT];

  add_digit #(.W(DIGIT)) u_slice (
    .a     (dig_a),
    .b     (dig_b),
    .ci    (carry_q),
    .s     (dig_s),
    .co    (dig_co),
    .c_msb (dig_cmsb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction is A + ~B + 1, so invert B and force the carry-in.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[dig_base +: DIGIT] = dig_s;
        carry_d = dig_co;
        if (cnt_q == LAST) begin
          cout_d  = dig_co;
          ovf_d   = dig_cmsb ^ dig_co;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_add_digit_serial.sv
// Directed and random checks of add_digit_serial at DIGIT = 4, 16 and 1.
module tb_add_digit_serial;
  import add_digit_serial_pkg::*;

  logic        clock, reset;
  logic [2:0]  start_v;
  logic        sub, cin;
  logic [15:0] a, b;
  logic [15:0] sum_w   [3];
  logic        cout_w  [3];
  logic        ovf_w   [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  state_e      state_w [3];

  int checks = 0;
  int errors = 0;
  int ndig_of [3] = '{4, 1, 16};

  add_digit_serial #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clock(clock), .reset(reset), .start(start_v[0]), .sub(sub), .cin(cin),
    .a(a), .b(b), .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .state_dbg(state_w[0]));

  add_digit_serial #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clock(clock), .reset(reset), .start(start_v[1]), .sub(sub), .cin(cin),
    .a(a), .b(b), .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .state_dbg(state_w[1]));

  add_digit_serial #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clock(clock), .reset(reset), .start(start_v[2]), .sub(sub), .cin(cin),
    .a(a), .b(b), .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .state_dbg(state_w[2]));

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        s;
    logic        c;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] e_sum;
    logic        e_cout;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: 17-bit add of A, (B or ~B) and the effective carry.
  task automatic model(input logic s, input logic c, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] es, output logic ec, output logic eo);
    logic [15:0] yy;
    logic [16:0] full;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {16'd0, (s ? 1'b1 : c)};
    es   = full[15:0];
    ec   = full[16];
    eo   = (x[15] == yy[15]) && (es[15] != x[15]);
  endtask

  // Driver: issue one op on instance idx and follow it until busy drops.
  task automatic run_op(input int idx, input logic s, input logic c,
                        input logic [15:0] x, input logic [15:0] y, input bit poke,
                        output logic [15:0] rs, output logic rc, output logic ro,
                        output int lat, output int busy_cyc, output int done_cnt);
    int n;
    @(negedge clock);
    sub = s; cin = c; a = x; b = y; start_v[idx] = 1'b1;
    @(negedge clock);
    start_v[idx] = 1'b0;
    lat = -1; busy_cyc = 0; done_cnt = 0; rs = '0; rc = 1'b0; ro = 1'b0;
    if (poke) begin
      sub = ~s; cin = ~c; a = ~x; b = y ^ 16'h5a5a;
    end
    n = 0;
    while (busy_w[idx] && n < 64) begin
      busy_cyc++;
      if (done_w[idx]) begin
        done_cnt++;
        lat = n;
        rs = sum_w[idx]; rc = cout_w[idx]; ro = ovf_w[idx];
        start_v[idx] = poke;
      end else begin
        start_v[idx] = (poke && n == 1);
      end
      @(negedge clock);
      n++;
    end
    start_v[idx] = 1'b0;
    if (n >= 64) begin
      errors++;
      checks++;
      $display("FAIL timeout: instance %0d still busy after %0d cycles, required idle", idx, n);
    end
  endtask

  task automatic op_check(input int idx, input string tag, input logic s, input logic c,
                          input logic [15:0] x, input logic [15:0] y, input bit poke,
                          input logic [15:0] es, input logic ec, input logic eo);
    logic [15:0] rs;
    logic rc, ro;
    int lat, bc, dc;
    run_op(idx, s, c, x, y, poke, rs, rc, ro, lat, bc, dc);
    chk({tag, " sum"},  32'(rs), 32'(es));
    chk({tag, " cout"}, 32'(rc), 32'(ec));
    chk({tag, " ovf"},  32'(ro), 32'(eo));
    chk({tag, " latency"}, 32'(lat), 32'(ndig_of[idx]));
    chk({tag, " busy_cycles"}, 32'(bc), 32'(ndig_of[idx] + 1));
    chk({tag, " done_pulses"}, 32'(dc), 32'd1);
  endtask

  initial begin
    logic [15:0] es, rx, ry;
    logic ec, eo, rs_, rc_;

    vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 16'h0010, 16'h0001, 16'h000F, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

    reset = 1'b1; start_v = '0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("reset sum", 32'(sum_w[i]), 32'd0);
      chk("reset flags", {28'd0, cout_w[i], ovf_w[i], busy_w[i], done_w[i]}, 32'd0);
      chk("reset state", 32'(state_w[i]), 32'(S_IDLE));
    end
    @(negedge clock);
    reset = 1'b0;

    // Directed table on all three digit widths
    for (int i = 0; i < 3; i++)
      for (int v = 0; v < 9; v++)
        op_check(i, $sformatf("vec%0d_inst%0d", v, i), vecs[v].s, vecs[v].c,
                 vecs[v].x, vecs[v].y, 1'b0, vecs[v].e_sum, vecs[v].e_cout, vecs[v].e_ovf);

    // start pulses with other operands during RUN and DONE are ignored
    for (int i = 0; i < 3; i++) begin
      op_check(i, $sformatf("poke_inst%0d", i), 1'b0, 1'b0, 16'h1234, 16'h4321, 1'b1,
               16'h5555, 1'b0, 1'b0);
      repeat (2) @(negedge clock);
      chk("poke no_reaccept", 32'(busy_w[i]), 32'd0);
      chk("poke sum_held", 32'(sum_w[i]), 32'h5555);
    end

    // Reset in the middle of a DIGIT=4 operation
    @(negedge clock);
    sub = 1'b0; cin = 1'b0; a = 16'h1234; b = 16'h4321; start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clock);
    chk("midrun partial_sum", 32'(sum_w[0]), 32'h0055);
    #2 reset = 1'b1;
    #1;
    chk("midrun reset sum", 32'(sum_w[0]), 32'd0);
    chk("midrun reset flags", {28'd0, cout_w[0], ovf_w[0], busy_w[0], done_w[0]}, 32'd0);
    chk("midrun reset state", 32'(state_w[0]), 32'(S_IDLE));
    @(negedge clock);
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (8) begin
        @(negedge clock);
        if (done_w[0] || busy_w[0]) seen++;
      end
      chk("midrun no_done_after_reset", 32'(seen), 32'd0);
    end
    op_check(0, "after_reset", 1'b0, 1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Random operations against the reference model
    for (int i = 0; i < 3; i++) begin
      int nops;
      nops = (i == 0) ? 1000 : 150;
      for (int k = 0; k < nops; k++) begin
        rx  = 16'($urandom_range(0, 65535));
        ry  = 16'($urandom_range(0, 65535));
        rs_ = 1'($urandom_range(0, 1));
        rc_ = 1'($urandom_range(0, 1));
        model(rs_, rc_, rx, ry, es, ec, eo);
        op_check(i, $sformatf("rand%0d_inst%0d", k, i), rs_, rc_, rx, ry, 1'b0, es, ec, eo);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
